// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the IF/ID hazard controller.
// Holds the FSM state encoding and opcode constants.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } ctrl_state_t;

   localparam logic [5:0] OP_LW = 6'b100011;

   // Sequencing count width; covers LOAD_STALL up to 7.
   localparam int CNT_W = 3;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard equation, shared with forwarding logic.
// Ports: mem_read/ex_rt from EX, id_rs/id_rt/uses_rt from ID, hazard out.
module hazard_detect (
   input  logic       mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       uses_rt,
   output logic       hazard
);

   // r0 is hard-wired zero, so a load into it never blocks anyone.
   assign hazard = mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) ||
                    (uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID and PC sequencing: load-use stalls, redirect flushes,
// fetch wait states and HALT.
// Ports: CLK, Reset (sync, active-high); ID_op/ID_rs/ID_rt/ID_UsesRt
// from ID; EX_MemRead/EX_rt from EX; BranchTaken; ImemReady.
// Outputs: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Halted.
// HAZARD_STATS_EN adds saturating StallCnt/FlushCnt outputs.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int         LOAD_STALL = 1,
   parameter int         BR_PENALTY = 1,
   parameter logic [5:0] HALT_OP    = 6'b111111
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [5:0]  ID_op,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_UsesRt,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_rt,
   input  logic        BranchTaken,
   input  logic        ImemReady,
   output logic        PCWrite,
   output logic        IF_ID_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Bubble,
   output logic        Halted
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] StallCnt,
   output logic [15:0] FlushCnt
`endif
);

   localparam logic [CNT_W-1:0] LS_INIT = CNT_W'(LOAD_STALL - 1);
   localparam logic [CNT_W-1:0] BR_INIT = CNT_W'(BR_PENALTY - 1);
   localparam bit LS_MULTI = (LOAD_STALL > 1);
   localparam bit BR_MULTI = (BR_PENALTY > 1);

   ctrl_state_t      state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             hazard;
   logic             is_halt;
   logic             stall_ev;

   hazard_detect u_hd (
      .mem_read (EX_MemRead),
      .ex_rt    (EX_rt),
      .id_rs    (ID_rs),
      .id_rt    (ID_rt),
      .uses_rt  (ID_UsesRt),
      .hazard   (hazard)
   );

   assign is_halt = (ID_op == HALT_OP);

   // State register
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         RUN: begin
            if (BranchTaken) begin
               if (BR_MULTI) begin
                  state_n = FLUSH;
                  cnt_n   = BR_INIT;
               end
            end else if (is_halt) begin
               state_n = HALT;
            end else if (hazard) begin
               if (LS_MULTI) begin
                  state_n = STALL;
                  cnt_n   = LS_INIT;
               end
            end
         end
         STALL: begin
            // A redirect makes the stalled instruction dead.
            if (BranchTaken) begin
               if (BR_MULTI) begin
                  state_n = FLUSH;
                  cnt_n   = BR_INIT;
               end else begin
                  state_n = RUN;
                  cnt_n   = '0;
               end
            end else begin
               cnt_n = cnt - 1'b1;
               if (cnt == CNT_W'(1)) state_n = RUN;
            end
         end
         FLUSH: begin
            // Flush slots only count once a fetch actually lands.
            if (ImemReady) begin
               cnt_n = cnt - 1'b1;
               if (cnt == CNT_W'(1)) state_n = RUN;
            end
         end
         HALT: begin
            state_n = HALT;
         end
      endcase
   end

   // Output logic
   always_comb begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      Halted       = 1'b0;
      stall_ev     = 1'b0;
      if (Reset) begin
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (BranchTaken) begin
                  PCWrite      = 1'b1;
                  IF_ID_Write  = 1'b1;
                  IF_ID_Flush  = 1'b1;
                  ID_EX_Bubble = 1'b1;
               end else if (is_halt) begin
                  ID_EX_Bubble = 1'b1;
               end else if (hazard) begin
                  ID_EX_Bubble = 1'b1;
                  stall_ev     = 1'b1;
               end else if (!ImemReady) begin
                  ID_EX_Bubble = 1'b1;
               end else begin
                  PCWrite      = 1'b1;
                  IF_ID_Write  = 1'b1;
               end
            end
            STALL: begin
               if (BranchTaken) begin
                  PCWrite      = 1'b1;
                  IF_ID_Write  = 1'b1;
                  IF_ID_Flush  = 1'b1;
                  ID_EX_Bubble = 1'b1;
               end else begin
                  ID_EX_Bubble = 1'b1;
                  stall_ev     = 1'b1;
               end
            end
            FLUSH: begin
               PCWrite      = ImemReady;
               IF_ID_Write  = 1'b1;
               IF_ID_Flush  = 1'b1;
               ID_EX_Bubble = 1'b1;
            end
            HALT: begin
               ID_EX_Bubble = 1'b1;
               Halted       = 1'b1;
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge CLK) begin
      if (Reset) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (stall_ev && (StallCnt != 16'hFFFF))
            StallCnt <= StallCnt + 16'd1;
         if (IF_ID_Flush && (FlushCnt != 16'hFFFF))
            FlushCnt <= FlushCnt + 16'd1;
      end
   end
`else
   logic unused_stall_ev;
   assign unused_stall_ev = stall_ev;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (LOAD_STALL=2, BR_PENALTY=2).
// Expected {PCWrite,IF_ID_Write,Flush,Bubble,Halted} per cycle.
module tb_pipe_hazard_ctrl;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic [5:0] ID_op = '0;
   logic [4:0] ID_rs = 5'd1;
   logic [4:0] ID_rt = 5'd2;
   logic       ID_UsesRt = 1'b0;
   logic       EX_MemRead = 1'b0;
   logic [4:0] EX_rt = '0;
   logic       BranchTaken = 1'b0;
   logic       ImemReady = 1'b1;
   logic       PCWrite, IF_ID_Write, IF_ID_Flush;
   logic       ID_EX_Bubble, Halted;
`ifdef HAZARD_STATS_EN
   logic [15:0] StallCnt, FlushCnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string      tag;
      logic [4:0] exp;
   } exp_t;

   exp_t sb[$];

   always #5 CLK = ~CLK;

   pipe_hazard_ctrl #(
      .LOAD_STALL (2),
      .BR_PENALTY (2),
      .HALT_OP    (6'b111111)
   ) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .ID_op        (ID_op),
      .ID_rs        (ID_rs),
      .ID_rt        (ID_rt),
      .ID_UsesRt    (ID_UsesRt),
      .EX_MemRead   (EX_MemRead),
      .EX_rt        (EX_rt),
      .BranchTaken  (BranchTaken),
      .ImemReady    (ImemReady),
      .PCWrite      (PCWrite),
      .IF_ID_Write  (IF_ID_Write),
      .IF_ID_Flush  (IF_ID_Flush),
      .ID_EX_Bubble (ID_EX_Bubble),
      .Halted       (Halted)
`ifdef HAZARD_STATS_EN
      ,
      .StallCnt     (StallCnt),
      .FlushCnt     (FlushCnt)
`endif
   );

   task automatic check(input string tag,
                        input logic [15:0] got,
                        input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Expected output codes {pcw,ifw,flush,bubble,halted}
   localparam logic [4:0] E_RST  = 5'b00110;
   localparam logic [4:0] E_RUN  = 5'b11000;
   localparam logic [4:0] E_BUB  = 5'b00010;
   localparam logic [4:0] E_BR   = 5'b11110;
   localparam logic [4:0] E_FWT  = 5'b01110;
   localparam logic [4:0] E_HALT = 5'b00011;

   // One cycle: drive inputs just after the edge, queue the expectation.
   task automatic cyc(input logic rst, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr,
                      input logic [4:0] ert, input logic br,
                      input logic imem, input string tag,
                      input logic [4:0] exp);
      exp_t e;
      @(posedge CLK);
      #1;
      Reset = rst; ID_op = op; ID_rs = rs; ID_rt = rt;
      ID_UsesRt = urt; EX_MemRead = mr; EX_rt = ert;
      BranchTaken = br; ImemReady = imem;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic idle(input string tag, input logic [4:0] exp);
      cyc(0, 6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, tag, exp);
   endtask

   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.tag,
               {11'd0, PCWrite, IF_ID_Write, IF_ID_Flush,
                ID_EX_Bubble, Halted},
               {11'd0, e.exp});
      end
   end

   initial begin
      // Reset and release
      cyc(1, 6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, "rst0", E_RST);
      cyc(1, 6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, "rst1", E_RST);
      idle("run0", E_RUN);
      idle("run1", E_RUN);

      // Load-use on rs: two bubble cycles then resume
      cyc(0, 6'd0, 5'd5, 5'd2, 0, 1, 5'd5, 0, 1, "lu_rs0", E_BUB);
      idle("lu_rs1", E_BUB);
      idle("lu_rs2", E_RUN);

      // Load-use on rt with UsesRt set
      cyc(0, 6'd0, 5'd1, 5'd7, 1, 1, 5'd7, 0, 1, "lu_rt0", E_BUB);
      idle("lu_rt1", E_BUB);
      idle("lu_rt2", E_RUN);

      // rt match but rt not a source: no stall
      cyc(0, 6'd0, 5'd1, 5'd7, 0, 1, 5'd7, 0, 1, "rt_nouse", E_RUN);

      // Load to r0 never stalls
      cyc(0, 6'd0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 1, "r0", E_RUN);

      // Branch overrides a simultaneous hazard
      cyc(0, 6'd0, 5'd5, 5'd2, 0, 1, 5'd5, 1, 1, "br_hz0", E_BR);
      idle("br_hz1", E_BR);
      idle("br_hz2", E_RUN);

      // Flush slot waits for fetch data
      cyc(0, 6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, "brw0", E_BR);
      cyc(0, 6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, "brw1", E_FWT);
      idle("brw2", E_BR);
      idle("brw3", E_RUN);

      // Branch during a stall abandons the stall
      cyc(0, 6'd0, 5'd5, 5'd2, 0, 1, 5'd5, 0, 1, "stbr0", E_BUB);
      cyc(0, 6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, "stbr1", E_BR);
      idle("stbr2", E_BR);
      idle("stbr3", E_RUN);

      // Branch beats HALT_OP
      cyc(0, 6'h3f, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, "brhalt0", E_BR);
      idle("brhalt1", E_BR);
      idle("brhalt2", E_RUN);

      // Fetch wait states
      for (int i = 0; i < 3; i++)
         cyc(0, 6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, "imem", E_BUB);
      idle("imem_go", E_RUN);

      // Reset in the middle of a stall
      cyc(0, 6'd0, 5'd5, 5'd2, 0, 1, 5'd5, 0, 1, "strst0", E_BUB);
      cyc(1, 6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, "strst1", E_RST);
      idle("strst2", E_RUN);

      // HALT: only Reset exits, even a branch is ignored
      cyc(0, 6'h3f, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, "halt0", E_BUB);
      for (int i = 0; i < 10; i++)
         cyc(0, 6'd0, 5'd5, 5'd2, 0, 1, 5'd5, (i == 4), 1,
             "halted", E_HALT);
      cyc(1, 6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, "halt_rst", E_RST);
      idle("halt_run0", E_RUN);
      idle("halt_run1", E_RUN);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && sb.size() > 0; i++)
         @(posedge CLK);
      @(posedge CLK);
      check("sb_drain", 16'(sb.size()), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
